// File: rtl/sram_pkg.sv
// sram_pkg: shared types and constants for the word-SRAM request controller
// and its byte-merge datapath.
package sram_pkg;

   localparam int unsigned SRAM_WORD_W   = 32;
   localparam int unsigned MASK_W        = 4;
   localparam int unsigned DEFAULT_DEPTH = 65536;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      RD_WAIT  = 2'd1,
      RMW_WAIT = 2'd2,
      RESP     = 2'd3
   } sram_state_e;

   // True when a write mask touches only some of the byte lanes.
   function automatic logic mask_is_partial(input logic [MASK_W-1:0] mask);
      return (mask != '0) && (mask != '1);
   endfunction

endpackage

// File: rtl/sram_ctrl_if.sv
// sram_ctrl_if: request and response channels between a bus master and the
// SRAM controller, both valid/ready handshaked.
interface sram_ctrl_if
   import sram_pkg::*;
#(
   parameter int unsigned BYTE_AW = 16
);

   logic                   req_valid;
   logic                   req_ready;
   logic                   req_wr;
   logic [BYTE_AW-1:0]     req_addr;
   logic [SRAM_WORD_W-1:0] req_wdata;
   logic [MASK_W-1:0]      req_wmask;

   logic                   resp_valid;
   logic                   resp_ready;
   logic [SRAM_WORD_W-1:0] resp_rdata;
   logic                   resp_err;

   modport master (
      output req_valid, req_wr, req_addr, req_wdata, req_wmask, resp_ready,
      input  req_ready, resp_valid, resp_rdata, resp_err
   );

   modport slave (
      input  req_valid, req_wr, req_addr, req_wdata, req_wmask, resp_ready,
      output req_ready, resp_valid, resp_rdata, resp_err
   );

endinterface

// File: rtl/sram_byte_merge.sv
// sram_byte_merge: per-byte-lane select between an old and a new word;
// lanes with their mask bit set take the new byte.
module sram_byte_merge
   import sram_pkg::*;
#(
   parameter int unsigned LANES = MASK_W
) (
   input  logic [8*LANES-1:0] old_i,
   input  logic [8*LANES-1:0] new_i,
   input  logic [LANES-1:0]   mask_i,
   output logic [8*LANES-1:0] merged_o
);

   always_comb begin
      merged_o = old_i;
      for (int unsigned i = 0; i < LANES; i++) begin
         if (mask_i[i]) begin
            merged_o[8*i +: 8] = new_i[8*i +: 8];
         end
      end
   end

endmodule

// File: rtl/sram_ctrl.sv
// sram_ctrl: byte-addressed request front end for a word SRAM with 1-cycle read;
// partial writes become read-modify-write. Optional macro: SRAM_CTRL_ALIGN_CHK_EN.
module sram_ctrl
   import sram_pkg::*;
#(
   parameter  int unsigned DEPTH   = DEFAULT_DEPTH,
   parameter  int unsigned BYTE_AW = $clog2(DEPTH),
   localparam int unsigned AW      = $clog2(DEPTH / 4)
) (
   input  logic                   clk,
   input  logic                   reset,
   sram_ctrl_if.slave             bus,
   output logic                   sram_wen,
   output logic [AW-1:0]          sram_waddr,
   output logic [SRAM_WORD_W-1:0] sram_wdata,
   output logic                   sram_ren,
   output logic [AW-1:0]          sram_raddr,
   input  logic [SRAM_WORD_W-1:0] sram_rdata
);

   sram_state_e            state_q, state_d;
   logic [AW-1:0]          addr_q, addr_d;
   logic [SRAM_WORD_W-1:0] wdata_q, wdata_d;
   logic [MASK_W-1:0]      mask_q, mask_d;
   logic [SRAM_WORD_W-1:0] rdata_q, rdata_d;
   logic [SRAM_WORD_W-1:0] merged;
   logic [AW-1:0]          req_word;
   logic                   accept;
   logic                   misaligned;

   assign req_word       = bus.req_addr[BYTE_AW-1:2];
   assign bus.req_ready  = (state_q == IDLE);
   assign bus.resp_valid = (state_q == RESP);
   assign bus.resp_rdata = rdata_q;
   assign accept         = bus.req_valid & bus.req_ready;

`ifdef SRAM_CTRL_ALIGN_CHK_EN
   logic err_q, err_d;

   assign misaligned   = |bus.req_addr[1:0];
   assign bus.resp_err = err_q;

   always_comb begin
      err_d = err_q;
      if (accept) begin
         err_d = misaligned;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         err_q <= 1'b0;
      end else begin
         err_q <= err_d;
      end
   end
`else
   logic unused_addr_lo;

   assign misaligned     = 1'b0;
   assign bus.resp_err   = 1'b0;
   assign unused_addr_lo = ^bus.req_addr[1:0];
`endif

   sram_byte_merge #(
      .LANES (MASK_W)
   ) u_merge (
      .old_i    (sram_rdata),
      .new_i    (wdata_q),
      .mask_i   (mask_q),
      .merged_o (merged)
   );

   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      mask_d     = mask_q;
      rdata_d    = rdata_q;
      sram_ren   = 1'b0;
      sram_raddr = addr_q;
      sram_wen   = 1'b0;
      sram_waddr = addr_q;
      sram_wdata = wdata_q;

      unique case (state_q)
         IDLE: begin
            if (accept) begin
               addr_d     = req_word;
               wdata_d    = bus.req_wdata;
               mask_d     = bus.req_wmask;
               rdata_d    = '0;
               sram_raddr = req_word;
               sram_waddr = req_word;
               sram_wdata = bus.req_wdata;
               if (misaligned) begin
                  state_d = RESP;
               end else if (!bus.req_wr) begin
                  sram_ren = 1'b1;
                  state_d  = RD_WAIT;
               end else if (mask_is_partial(bus.req_wmask)) begin
                  sram_ren = 1'b1;
                  state_d  = RMW_WAIT;
               end else begin
                  sram_wen = (bus.req_wmask == '1);
                  state_d  = RESP;
               end
            end
         end
         RD_WAIT: begin
            rdata_d = sram_rdata;
            state_d = RESP;
         end
         RMW_WAIT: begin
            sram_wen   = 1'b1;
            sram_wdata = merged;
            state_d    = RESP;
         end
         RESP: begin
            if (bus.resp_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      // Enables are combinational, so gate them here: a reset landing in
      // RMW_WAIT must never let the merge write reach the array.
      if (reset) begin
         sram_ren = 1'b0;
         sram_wen = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         addr_q  <= '0;
         wdata_q <= '0;
         mask_q  <= '0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         mask_q  <= mask_d;
         rdata_q <= rdata_d;
      end
   end

endmodule
